// File: rtl/op2_pkg.sv
// Shared opcode and second-operand select-code constants for the op2 stage.
package op2_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] SEL_PB    = 3'd0;
  localparam logic [2:0] SEL_IMM_I = 3'd1;
  localparam logic [2:0] SEL_IMM_S = 3'd2;
  localparam logic [2:0] SEL_IMM_U = 3'd3;
  localparam logic [2:0] SEL_PC    = 3'd4;
  localparam logic [2:0] SEL_ZERO  = 3'd5;

endpackage

// File: rtl/op2_sel_decode.sv
// Combinational opcode -> {second-operand select, illegal} lookup.
module op2_sel_decode
  import op2_pkg::*;
#(
  parameter logic [2:0] BUBBLE_SEL = SEL_ZERO
) (
  input  logic [6:0] opcode,
  output logic [2:0] sel,
  output logic       illegal
);

  always_comb begin
    sel     = BUBBLE_SEL;
    illegal = 1'b0;
    case (opcode)
      OPC_RTYPE, OPC_BRANCH: sel = SEL_PB;
      OPC_IALU, OPC_LOAD:    sel = SEL_IMM_I;
      OPC_STORE:             sel = SEL_IMM_S;
      OPC_LUI, OPC_AUIPC:    sel = SEL_IMM_U;
      OPC_JAL, OPC_JALR:     sel = SEL_PC;
      default:               illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/op2_sel_stage.sv
// ID->EX stage registering the second-operand mux select, raw immediates and PC.
// Optional saturating illegal-opcode counter enabled by defining OP2_ILLEGAL_CNT_EN.
module op2_sel_stage
  import op2_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter logic [2:0]  BUBBLE_SEL = 3'b101,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [XLEN-1:0]  instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [2:0]       S,
  output logic [11:0]      imm12_I,
  output logic [11:0]      imm12_S,
  output logic [19:0]      imm20,
  output logic [XLEN-1:0]  pc_out,
`ifdef OP2_ILLEGAL_CNT_EN
  output logic [CNT_W-1:0] illegal_cnt,
`endif
  output logic             illegal
);

  // Valid protocol: if_valid qualifies instr/pc_in on each edge with no
  // backpressure; ex_valid qualifies every registered output. stall holds the
  // stage, flush (higher priority) turns it into a bubble.
  logic [2:0]      w_sel;
  logic            w_illegal;
  logic            w_load;

  logic            r_valid;
  logic [2:0]      r_sel;
  logic [11:0]     r_imm_i;
  logic [11:0]     r_imm_s;
  logic [19:0]     r_imm20;
  logic [XLEN-1:0] r_pc;
  logic            r_illegal;

  op2_sel_decode #(.BUBBLE_SEL(BUBBLE_SEL)) u_decode (
    .opcode  (instr[6:0]),
    .sel     (w_sel),
    .illegal (w_illegal)
  );

  assign w_load = !flush && !stall && if_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_sel     <= BUBBLE_SEL;
      r_imm_i   <= '0;
      r_imm_s   <= '0;
      r_imm20   <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_sel     <= w_sel;
      r_imm_i   <= instr[31:20];
      r_imm_s   <= {instr[31:25], instr[11:7]};
      r_imm20   <= instr[31:12];
      r_pc      <= pc_in;
      r_illegal <= w_illegal;
    end else if (flush || !stall) begin
      r_valid   <= 1'b0;
      r_sel     <= BUBBLE_SEL;
      r_imm_i   <= '0;
      r_imm_s   <= '0;
      r_imm20   <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end
  end

`ifdef OP2_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] r_illegal_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_cnt <= '0;
    end else if (w_load && w_illegal && (r_illegal_cnt != {CNT_W{1'b1}})) begin
      r_illegal_cnt <= r_illegal_cnt + 1'b1;
    end
  end

  assign illegal_cnt = r_illegal_cnt;
`endif

  assign ex_valid = r_valid;
  assign S        = r_sel;
  assign imm12_I  = r_imm_i;
  assign imm12_S  = r_imm_s;
  assign imm20    = r_imm20;
  assign pc_out   = r_pc;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_op2_sel_stage.sv
// Scoreboard bench for op2_sel_stage: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_op2_sel_stage;

  localparam int CNT_W = 16;
`ifdef OP2_ILLEGAL_CNT_EN
  localparam int W = 81 + CNT_W;
`else
  localparam int W = 81;
`endif

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [2:0]  S;
  logic [11:0] imm12_I;
  logic [11:0] imm12_S;
  logic [19:0] imm20;
  logic [31:0] pc_out;
  logic        illegal;
`ifdef OP2_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] illegal_cnt;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [W-1:0] last_exp;
  logic [CNT_W-1:0] exp_cnt;
  int checks;
  int failures;

  op2_sel_stage #(.XLEN(32), .BUBBLE_SEL(3'b101), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_valid (if_valid),
    .instr    (instr),
    .pc_in    (pc_in),
    .stall    (stall),
    .flush    (flush),
    .ex_valid (ex_valid),
    .S        (S),
    .imm12_I  (imm12_I),
    .imm12_S  (imm12_S),
    .imm20    (imm20),
    .pc_out   (pc_out),
`ifdef OP2_ILLEGAL_CNT_EN
    .illegal_cnt (illegal_cnt),
`endif
    .illegal  (illegal)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input logic v, input logic [2:0] s,
      input logic [11:0] ii, input logic [11:0] is, input logic [19:0] u,
      input logic [31:0] pc, input logic ill, input logic [CNT_W-1:0] cnt);
`ifdef OP2_ILLEGAL_CNT_EN
    return {v, s, ii, is, u, pc, ill, cnt};
`else
    return {v, s, ii, is, u, pc, ill} | ((cnt & '0) != 0 ? 81'd0 : 81'd0);
`endif
  endfunction

  function automatic logic [W-1:0] bubble(input logic [CNT_W-1:0] cnt);
    return pack(1'b0, 3'd5, 12'd0, 12'd0, 20'd0, 32'd0, 1'b0, cnt);
  endfunction

  function automatic logic [W-1:0] actual();
`ifdef OP2_ILLEGAL_CNT_EN
    return pack(ex_valid, S, imm12_I, imm12_S, imm20, pc_out, illegal, illegal_cnt);
`else
    return pack(ex_valid, S, imm12_I, imm12_S, imm20, pc_out, illegal, '0);
`endif
  endfunction

  // driver: inputs change at negedge, expectation is pushed after the edge
  task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
      input logic [31:0] pc, input logic st, input logic fl,
      input logic [2:0] exp_s, input logic exp_ill, input string name);
    logic [W-1:0] e;
    @(negedge clk);
    rst_n = rst; if_valid = iv; instr = ins; pc_in = pc; stall = st; flush = fl;
    @(posedge clk);
    if (!rst) begin
      exp_cnt = '0;
      e = bubble(exp_cnt);
    end else if (fl) begin
      e = bubble(exp_cnt);
    end else if (st) begin
      e = last_exp;
    end else if (iv) begin
      if (exp_ill && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
      e = pack(1'b1, exp_s, ins[31:20], {ins[31:25], ins[11:7]}, ins[31:12], pc, exp_ill, exp_cnt);
    end else begin
      e = bubble(exp_cnt);
    end
    last_exp = e;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (actual() !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", n, actual(), e);
      end
    end
  end

  initial begin
    checks = 0; failures = 0; exp_cnt = '0;
    last_exp = bubble('0);
    rst_n = 1'b0; if_valid = 1'b0; instr = '0; pc_in = '0; stall = 1'b0; flush = 1'b0;

    step(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, "reset0");
    step(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, "reset1");
    step(1'b1, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0, 3'd1, 1'b0, "addi");
    step(1'b1, 1'b1, 32'hFE112E23, 32'h4, 1'b0, 1'b0, 3'd2, 1'b0, "sw");
    step(1'b1, 1'b1, 32'h123450B7, 32'h8, 1'b0, 1'b0, 3'd3, 1'b0, "lui");
    step(1'b1, 1'b1, 32'h008000EF, 32'h100, 1'b0, 1'b0, 3'd4, 1'b0, "jal");
    step(1'b1, 1'b1, 32'h002081B3, 32'h104, 1'b0, 1'b0, 3'd0, 1'b0, "rtype");
    step(1'b1, 1'b1, 32'h00000013, 32'h200, 1'b1, 1'b0, 3'd0, 1'b0, "stall0");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h204, 1'b1, 1'b0, 3'd0, 1'b0, "stall1");
    step(1'b1, 1'b0, 32'h123450B7, 32'h208, 1'b1, 1'b0, 3'd0, 1'b0, "stall2");
    step(1'b1, 1'b1, 32'h00500093, 32'h20C, 1'b1, 1'b1, 3'd0, 1'b0, "stall_flush");
    step(1'b1, 1'b1, 32'h00000063, 32'h300, 1'b0, 1'b0, 3'd0, 1'b0, "branch");
    step(1'b1, 1'b1, 32'h00008067, 32'h304, 1'b0, 1'b0, 3'd4, 1'b0, "jalr");
    step(1'b1, 1'b1, 32'h00000097, 32'h308, 1'b0, 1'b0, 3'd3, 1'b0, "auipc");
    step(1'b1, 1'b1, 32'h00002083, 32'h30C, 1'b0, 1'b0, 3'd1, 1'b0, "lw");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h400, 1'b0, 1'b0, 3'd5, 1'b1, "illegal0");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h404, 1'b0, 1'b0, 3'd5, 1'b1, "illegal1");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h408, 1'b0, 1'b0, 3'd5, 1'b1, "illegal2");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h40C, 1'b1, 1'b0, 3'd0, 1'b0, "illegal_stall");
    step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h410, 1'b0, 1'b1, 3'd0, 1'b0, "illegal_flush");
    step(1'b1, 1'b0, 32'h00500093, 32'h414, 1'b0, 1'b0, 3'd0, 1'b0, "no_valid");
    step(1'b1, 1'b0, 32'hFFFFFFFF, 32'h418, 1'b0, 1'b0, 3'd0, 1'b0, "no_valid_ill");
`ifdef OP2_ILLEGAL_CNT_EN
    for (int i = 0; i < (1 << CNT_W); i++)
      step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h500, 1'b0, 1'b0, 3'd5, 1'b1, "illegal_sat");
`endif
    step(1'b1, 1'b1, 32'h123450B7, 32'h600, 1'b0, 1'b0, 3'd3, 1'b0, "pre_async");

    // async reset asserted mid-cycle while stalled must clear immediately
    @(negedge clk);
    stall = 1'b1; flush = 1'b0; if_valid = 1'b1; instr = 32'h00500093;
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_cnt = '0;
    last_exp = bubble(exp_cnt);
    exp_q.push_back(last_exp);
    name_q.push_back("async_reset");
    step(1'b0, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, "reset_hold");
    step(1'b1, 1'b1, 32'h00500093, 32'h700, 1'b0, 1'b0, 3'd1, 1'b0, "post_reset");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/op2_sel_stage.md
Name: op2_sel_stage

Overview:
- ID→EX pipeline stage that decodes the fetched instruction and registers everything the second-operand mux consumes.
- Registered outputs: the 3-bit select code S, raw immediate fields imm12_I, imm12_S and imm20, and PC.
- Sits between fetch/decode and the EX second-operand mux; drives that mux's S/imm/PC inputs directly.
- Adds valid tracking, stall (hold) and flush (bubble) control.

Parameters:
- XLEN, 32, datapath width of instr/PC.
- BUBBLE_SEL, 3'b101, select code loaded for bubbles/reset (mux outputs zero).
- CNT_W, 16, width of the illegal-opcode counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  instr/pc_in hold a real instruction
- instr  in  XLEN  instruction word from fetch
- pc_in  in  XLEN  PC of instr
- stall  in  1  hold all stage registers
- flush  in  1  replace stage contents with a bubble
- ex_valid  out  1  stage holds a valid instruction
- S  out  3  second-operand select: 0 PB, 1 imm12_I, 2 imm12_S, 3 imm20<<12, 4 PC, 5–7 zero
- imm12_I  out  12  instr[31:20]
- imm12_S  out  12  {instr[31:25], instr[11:7]}
- imm20  out  20  instr[31:12]
- pc_out  out  XLEN  registered PC
- illegal  out  1  valid instruction with an unrecognised opcode
- illegal_cnt  out  CNT_W  saturating count of illegal instructions (ILLEGAL_CNT_EN only)

Behaviour:
- Reset (async, rst_n=0): ex_valid=0, S=BUBBLE_SEL, imm12_I/imm12_S/imm20=0, pc_out=0, illegal=0, illegal_cnt=0. Release takes effect on the next clk edge.
- Latency: 1 cycle. Outputs reflect the instr presented at the previous edge.
- Edge priority: flush > stall > load.
  - flush=1: bubble (ex_valid=0, S=BUBBLE_SEL, imm fields=0, pc_out=0, illegal=0), regardless of stall.
  - stall=1, flush=0: every output register holds, including illegal_cnt.
  - Otherwise with if_valid=1: capture decoded fields, ex_valid=1, pc_out=pc_in.
  - Otherwise with if_valid=0: bubble.
- Opcode (instr[6:0]) → S:
  - 0110011 R-type → 0; 1100011 branch → 0
  - 0010011 I-ALU → 1; 0000011 load → 1
  - 0100011 store → 2
  - 0110111 LUI → 3; 0010111 AUIPC → 3
  - 1101111 JAL → 4; 1100111 JALR → 4
  - any other opcode → BUBBLE_SEL with illegal=1
- Immediate fields are captured raw for every valid instruction, independent of opcode; sign-extension and shifting stay in the mux.
- illegal is only ever 1 while ex_valid=1.
- Reset asserted mid-stall or mid-flush: reset wins immediately.

Optional Feature:
- Macro: OP2_ILLEGAL_CNT_EN.
- Defined:
  - illegal_cnt increments by 1 on each edge that loads an instruction with illegal=1.
  - Saturates at all-ones; does not increment on stall or flush edges.
  - Cleared only by reset.
- Undefined: illegal_cnt port is absent and no counter logic is built.

Decomposition:
- Shared package op2_pkg:
  - opcode localparams (OPC_RTYPE, OPC_IALU, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR)
  - select-code constants (SEL_PB=0, SEL_IMM_I=1, SEL_IMM_S=2, SEL_IMM_U=3, SEL_PC=4, SEL_ZERO=5)
- One sub-module, op2_sel_decode: purely combinational opcode→{S, illegal} lookup, instantiated once ahead of the stage registers.

Test Plan:
- Reset: hold rst_n=0, drive instr=32'h00500093 with if_valid=1 → ex_valid=0, S=5, all imm fields 0. After release, one edge → S=1, imm12_I=12'h005, ex_valid=1.
- Store: load 32'hFE112E23 (sw) → S=2, imm12_S=12'hFFC, illegal=0.
- Upper/jump: LUI 32'h123450B7 → S=3, imm20=20'h12345. Next edge JAL 32'h008000EF with pc_in=32'h100 → S=4, pc_out=32'h100.
- Stall/flush priority:
  - Load R-type 32'h002081B3 → S=0.
  - stall=1 for 3 cycles with changing instr → outputs unchanged.
  - stall=1 and flush=1 together → bubble (ex_valid=0, S=5).
- Illegal: instr=32'hFFFFFFFF with if_valid=1 → S=5, illegal=1, ex_valid=1. With OP2_ILLEGAL_CNT_EN, 3 such loads → illegal_cnt=3; preload to all-ones → stays all-ones.
- if_valid=0 with valid-looking instr → bubble, illegal=0, counter unchanged.
